// File: rtl/alu_pkg.sv
// Shared types and sizing for the ALU op sequencer.
// Optional feature macro: ALU_SEQ_IMM_EN (immediate B operand).
package alu_pkg;

  localparam int DATA_W = 4;
  localparam int NREG   = 4;
  localparam int RW     = $clog2(NREG);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_SHR = 2'b10,
    OP_SHL = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } seq_state_t;

  typedef struct packed {
    alu_op_t           op;
    logic [RW-1:0]     rd;
    logic [RW-1:0]     ra;
    logic [RW-1:0]     rb;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
  } cmd_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file for the ALU op sequencer: NREG x DATA_W, one synchronous
// write port, two asynchronous command read ports, one asynchronous debug
// read port, synchronous clear.
module alu_seq_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [RW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [RW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem [NREG];

  // Storage: clear everything on reset, otherwise write one entry when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register file is architecturally visible and must read 0
      // after reset, so every entry is cleared here (this keeps it in
      // flops rather than a RAM macro, which is fine at this size).
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads are combinational, so a write becomes visible the cycle after its edge.
  assign rdata_a  = mem[raddr_a];
  assign rdata_b  = mem[raddr_b];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: accepts register-to-register commands on a valid/ready
// port, drives an external combinational ALU for one cycle, then writes the
// result and flag back. One command every three cycles.
// Optional feature macro: ALU_SEQ_IMM_EN -- when defined, cmd_use_imm selects
// cmd_imm as operand B; when undefined both immediate ports are ignored.
module alu_op_sequencer
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [RW-1:0]     cmd_rd,
  input  logic [RW-1:0]     cmd_ra,
  input  logic [RW-1:0]     cmd_rb,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic              cmd_use_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_flag,
  output logic              done,
  output logic              flag,
  output logic              busy,
  input  logic [RW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  seq_state_t        state, state_nxt;
  cmd_t              cmd_in;
  logic              accept;
  logic              wr_en;
  logic [RW-1:0]     rd_q;
  logic [DATA_W-1:0] rdata_a, rdata_b, b_sel;

  assign cmd_in = '{op:      alu_op_t'(cmd_op),
                    rd:      cmd_rd,
                    ra:      cmd_ra,
                    rb:      cmd_rb,
                    imm:     cmd_imm,
                    use_imm: cmd_use_imm};

  assign accept = cmd_valid && cmd_ready;

  alu_seq_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (wr_en),
    .waddr    (rd_q),
    .wdata    (alu_res),
    .raddr_a  (cmd_in.ra),
    .rdata_a  (rdata_a),
    .raddr_b  (cmd_in.rb),
    .rdata_b  (rdata_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

`ifdef ALU_SEQ_IMM_EN
  assign b_sel = cmd_in.use_imm ? cmd_in.imm : rdata_b;
`else
  logic unused_imm;
  assign b_sel      = rdata_b;
  assign unused_imm = ^{cmd_in.imm, cmd_in.use_imm};
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always updated with non-blocking assignments
    // so every flop samples pre-edge values regardless of block ordering.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control decode.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    wr_en     = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        wr_en     = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture at the handshake edge and flag capture at writeback.
  // Sampling operands at the handshake means rd==ra/rb naturally reads the
  // old value, since the write only lands at the end of EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      rd_q    <= '0;
      flag    <= 1'b0;
    end else begin
      if (accept) begin
        alu_a   <= rdata_a;
        alu_b   <= b_sel;
        alu_sel <= cmd_in.op;
        rd_q    <= cmd_in.rd;
      end
      if (wr_en) flag <= alu_flag;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer. Models the external 4-bit ALU,
// keeps a reference copy of the register file, and scoreboards writebacks.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [RW-1:0]     cmd_rd, cmd_ra, cmd_rb;
  logic [DATA_W-1:0] cmd_imm;
  logic              cmd_use_imm;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [1:0]        alu_sel;
  logic [DATA_W-1:0] alu_res;
  logic              alu_flag;
  logic              done, flag, busy;
  logic [RW-1:0]     dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [RW-1:0]     rd;
    logic [DATA_W-1:0] val;
    logic              flg;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] model [NREG];

  // ALU preload override: lets the bench place arbitrary values in registers.
  logic              force_en;
  logic [DATA_W-1:0] force_val;
  logic [DATA_W:0]   alu_full;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_op_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_rd      (cmd_rd),
    .cmd_ra      (cmd_ra),
    .cmd_rb      (cmd_rb),
    .cmd_imm     (cmd_imm),
    .cmd_use_imm (cmd_use_imm),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_res     (alu_res),
    .alu_flag    (alu_flag),
    .done        (done),
    .flag        (flag),
    .busy        (busy),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // External 4-bit ALU: result in bits [3:0], carry/borrow/spill in bit 4.
  function automatic logic [DATA_W:0] alu_model(input logic [1:0] sel,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] t;
    logic [DATA_W:0] s;
    s = {a, 1'b0} >> b;
    case (sel)
      2'b00:   t = {1'b0, a} + {1'b0, b};
      2'b01:   t = {1'b0, a} - {1'b0, b};
      2'b10:   t = {s[0], s[DATA_W:1]};
      default: t = {1'b0, a} << b;
    endcase
    return t;
  endfunction

  always_comb begin
    alu_full = '0;
    if (force_en) alu_full = {1'b0, force_val};
    else          alu_full = alu_model(alu_sel, alu_a, alu_b);
  end
  assign alu_res  = alu_full[DATA_W-1:0];
  assign alu_flag = alu_full[DATA_W];

  // One command through the full handshake / EXEC / DONE sequence, with
  // latency, operand, hazard-read and writeback checks. Starts at a negedge.
  task automatic do_cmd(input logic [1:0] op, input int rd, input int ra, input int rb,
                        input logic ui, input logic [DATA_W-1:0] iv,
                        input logic [DATA_W-1:0] exp_val, input logic exp_flg,
                        input string name);
    exp_t              e;
    int                k;
    logic [DATA_W-1:0] a_exp, b_exp, old_val;
    k = 0;
    while (!cmd_ready && k < 10) begin @(negedge clk); k++; end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL %s/ready_before: got %b want 1", name, cmd_ready); end
    a_exp = model[ra];
    b_exp = model[rb];
`ifdef ALU_SEQ_IMM_EN
    if (ui) b_exp = iv;
`endif
    old_val     = model[rd];
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_rd      = rd[RW-1:0];
    cmd_ra      = ra[RW-1:0];
    cmd_rb      = rb[RW-1:0];
    cmd_use_imm = ui;
    cmd_imm     = iv;
    e.rd  = rd[RW-1:0];
    e.val = exp_val;
    e.flg = exp_flg;
    sb.push_back(e);
    model[rd] = exp_val;
    // Cycle N+1: EXEC
    @(negedge clk);
    cmd_valid = 1'b0;
    dbg_addr  = rd[RW-1:0];
    #1;
    n_cmp++; if (busy !== 1'b1)      begin n_err++; $display("FAIL %s/busy_exec: got %b want 1", name, busy); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL %s/ready_exec: got %b want 0", name, cmd_ready); end
    n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL %s/done_early: got %b want 0", name, done); end
    n_cmp++; if (alu_a !== a_exp)    begin n_err++; $display("FAIL %s/alu_a: got %h want %h", name, alu_a, a_exp); end
    n_cmp++; if (alu_b !== b_exp)    begin n_err++; $display("FAIL %s/alu_b: got %h want %h", name, alu_b, b_exp); end
    n_cmp++; if (alu_sel !== op)     begin n_err++; $display("FAIL %s/alu_sel: got %b want %b", name, alu_sel, op); end
    n_cmp++; if (dbg_data !== old_val) begin n_err++; $display("FAIL %s/dbg_old: got %h want %h", name, dbg_data, old_val); end
    // Cycle N+2: DONE
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL %s/done_latency: got %b want 1", name, done); end
    n_cmp++; if (sb.size() == 0) begin n_err++; $display("FAIL %s/scoreboard: got empty want 1 entry", name); end
    else begin
      e = sb.pop_front();
      dbg_addr = e.rd;
      #1;
      n_cmp++; if (dbg_data !== e.val) begin n_err++; $display("FAIL %s/result: got %h want %h", name, dbg_data, e.val); end
      n_cmp++; if (flag !== e.flg)     begin n_err++; $display("FAIL %s/flag: got %b want %b", name, flag, e.flg); end
    end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL %s/done_pulse: got %b want 0", name, done); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL %s/ready_after: got %b want 1", name, cmd_ready); end
  endtask

  task automatic load_reg(input int rd, input logic [DATA_W-1:0] v);
    force_en  = 1'b1;
    force_val = v;
    do_cmd(2'(OP_ADD), rd, 0, 0, 1'b0, '0, v, 1'b0, "load");
    force_en  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset/ready: got %b want 1", cmd_ready); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset/busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset/done: got %b want 0", done); end
    n_cmp++; if (flag !== 1'b0)      begin n_err++; $display("FAIL reset/flag: got %b want 0", flag); end
    n_cmp++; if ({alu_a, alu_b, alu_sel} !== '0) begin n_err++; $display("FAIL reset/alu_out: got %h want 0", {alu_a, alu_b, alu_sel}); end
    for (int r = 0; r < NREG; r++) begin
      dbg_addr = r[RW-1:0];
      #1;
      n_cmp++; if (dbg_data !== '0) begin n_err++; $display("FAIL reset/reg%0d: got %h want 0", r, dbg_data); end
      model[r] = '0;
    end
    @(negedge clk);
  endtask

  task automatic test_arith();
    load_reg(1, 4'h9);
    load_reg(2, 4'h8);
    do_cmd(2'(OP_ADD), 3, 1, 2, 1'b0, '0, 4'h1, 1'b1, "add_carry");
    do_cmd(2'(OP_SUB), 3, 2, 1, 1'b0, '0, 4'hF, 1'b1, "sub_borrow");
    do_cmd(2'(OP_SUB), 3, 1, 2, 1'b0, '0, 4'h1, 1'b0, "sub_plain");
  endtask

  // Immediate select: honoured only when the feature is built in.
  task automatic test_imm();
`ifdef ALU_SEQ_IMM_EN
    do_cmd(2'(OP_SUB), 3, 1, 2, 1'b1, 4'h7, 4'h2, 1'b0, "imm_sel");
`else
    do_cmd(2'(OP_SUB), 3, 1, 2, 1'b1, 4'h7, 4'h1, 1'b0, "imm_ignored");
`endif
  endtask

  task automatic test_shift();
    load_reg(1, 4'hC);
    load_reg(2, 4'h1);
    do_cmd(2'(OP_SHL), 3, 1, 2, 1'b0, '0, 4'h8, 1'b1, "shl");
    load_reg(2, 4'h2);
    do_cmd(2'(OP_SHR), 3, 1, 2, 1'b0, '0, 4'h3, 1'b0, "shr");
    load_reg(2, 4'h5);
    do_cmd(2'(OP_SHL), 3, 1, 2, 1'b0, '0, 4'h0, 1'b0, "shl_wide");
  endtask

  task automatic test_hazard();
    load_reg(1, 4'h5);
    do_cmd(2'(OP_ADD), 1, 1, 1, 1'b0, '0, 4'hA, 1'b0, "hazard_rd_ra");
  endtask

  // cmd_valid held high: exactly one accept every 3 cycles, none lost or doubled.
  task automatic test_back_to_back();
    localparam int N = 5;
    logic [1:0]      ops [N] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    int              rds [N] = '{0, 3, 2, 1, 0};
    int              ras [N] = '{1, 2, 1, 0, 0};
    int              rbs [N] = '{2, 1, 2, 3, 3};
    int              idx = 0, dones = 0, last_acc = 0;
    logic            acc;
    logic [DATA_W:0] r;
    exp_t            e;
    cmd_valid = 1'b1; cmd_use_imm = 1'b0;
    cmd_op = ops[0]; cmd_rd = rds[0][RW-1:0]; cmd_ra = ras[0][RW-1:0]; cmd_rb = rbs[0][RW-1:0];
    for (int c = 0; c < 60 && dones < N; c++) begin
      acc = 1'b0;
      if (cmd_valid && cmd_ready) begin
        r = alu_model(ops[idx], model[ras[idx]], model[rbs[idx]]);
        e.rd = rds[idx][RW-1:0]; e.val = r[DATA_W-1:0]; e.flg = r[DATA_W];
        sb.push_back(e);
        model[rds[idx]] = r[DATA_W-1:0];
        if (idx > 0) begin
          n_cmp++; if (cyc - last_acc != 3) begin n_err++; $display("FAIL b2b/spacing: got %0d want 3", cyc - last_acc); end
        end
        last_acc = cyc;
        idx++;
        acc = 1'b1;
      end
      @(negedge clk);
      if (acc) begin
        if (idx < N) begin
          cmd_op = ops[idx]; cmd_rd = rds[idx][RW-1:0]; cmd_ra = ras[idx][RW-1:0]; cmd_rb = rbs[idx][RW-1:0];
        end else cmd_valid = 1'b0;
      end
      #1;
      if (busy) begin
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL b2b/ready_busy: got %b want 0", cmd_ready); end
      end
      if (done) begin
        dones++;
        n_cmp++; if (sb.size() == 0) begin n_err++; $display("FAIL b2b/extra_done: got done want none"); end
        else begin
          e = sb.pop_front();
          dbg_addr = e.rd;
          #1;
          n_cmp++; if (dbg_data !== e.val) begin n_err++; $display("FAIL b2b/result: got %h want %h", dbg_data, e.val); end
          n_cmp++; if (flag !== e.flg)     begin n_err++; $display("FAIL b2b/flag: got %b want %b", flag, e.flg); end
        end
      end
    end
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (idx != N)     begin n_err++; $display("FAIL b2b/accepts: got %0d want %0d", idx, N); end
    n_cmp++; if (dones != N)   begin n_err++; $display("FAIL b2b/dones: got %0d want %0d", dones, N); end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL b2b/leftover: got %0d want 0", sb.size()); end
  endtask

  // Reset asserted during EXEC: no writeback, no done, idle next cycle.
  task automatic test_reset_mid_op();
    force_en = 1'b1; force_val = 4'h7;
    cmd_valid = 1'b1; cmd_op = 2'(OP_ADD); cmd_rd = 2'd2; cmd_ra = 2'd1; cmd_rb = 2'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_mid/busy_exec: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rst_mid/busy: got %b want 0", busy); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid/ready: got %b want 1", cmd_ready); end
    n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL rst_mid/done: got %b want 0", done); end
    @(negedge clk);
    dbg_addr = 2'd2;
    #1;
    n_cmp++; if (done !== 1'b0)     begin n_err++; $display("FAIL rst_mid/done_late: got %b want 0", done); end
    n_cmp++; if (dbg_data !== '0)   begin n_err++; $display("FAIL rst_mid/rd_value: got %h want 0", dbg_data); end
    n_cmp++; if (flag !== 1'b0)     begin n_err++; $display("FAIL rst_mid/flag: got %b want 0", flag); end
    force_en = 1'b0;
    for (int r = 0; r < NREG; r++) model[r] = '0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
    cmd_imm = '0; cmd_use_imm = 1'b0; dbg_addr = '0; force_en = 1'b0; force_val = '0;
    test_reset();
    test_arith();
    test_imm();
    test_shift();
    test_hazard();
    test_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
